spi_initiator: RTL and testbench

SPI mode-0 initiator (controller) that drives `spi_sck_o`, `spi_copi_o` and `spi_cs_o`, and samples `spi_cipo_i`, one byte per handshake. It is the opposite end of the Xosera SPI target link. It sits in test and bring-up logic, for example an FPGA-side host or a loopback bench, and drives the target from a system clock at least 4x the SCK rate. Each byte is full-duplex: it shifts out `transmit_byte_i` and captures the received byte. Chip-select can be held across multi-byte transactions.

---
 rtl/spi_initiator_if.sv | 15 +
 rtl/spi_initiator.sv | 102 ++++++++++
 tb/tb_spi_initiator.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_initiator_if.sv
// Host-side byte handshake of the SPI mode-0 initiator.
// The host drives start/data/last; the initiator returns busy and the received byte.
interface spi_initiator_if;
    logic       start_i;
    logic [7:0] transmit_byte_i;
    logic       last_i;
    logic       busy_o;
    logic       receive_strobe_o;
    logic [7:0] receive_byte_o;

    modport master (output start_i, transmit_byte_i, last_i,
                    input  busy_o, receive_strobe_o, receive_byte_o);
    modport slave  (input  start_i, transmit_byte_i, last_i,
                    output busy_o, receive_strobe_o, receive_byte_o);
endinterface

// File: rtl/spi_initiator.sv
// SPI mode-0 initiator: one full-duplex byte per accepted start, MSB first.
// CS stays low between bytes unless the byte was tagged last.
module spi_initiator #(
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset_n_i,
    spi_initiator_if.slave   host,
    output logic             spi_sck_o,
    output logic             spi_copi_o,
    output logic             spi_cs_o,
    input  logic             spi_cipo_i
);
    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SCK_HIGH, SCK_LOW, CS_HOLD, CS_GAP} state_t;

    state_t     state, state_next;
    logic [7:0] shreg, div_cnt, rx_byte;
    logic [2:0] bit_cnt;
    logic       last_flag, sck, copi, cs, strobe;
    logic       accept, div_done;

    assign accept   = (state == IDLE) && host.start_i;
    assign div_done = (div_cnt == 8'd0);

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept)   state_next = SETUP;
            SETUP:    if (div_done) state_next = SCK_HIGH;
            SCK_HIGH: if (div_done) state_next = SCK_LOW;
            SCK_LOW:  if (div_done) state_next = (bit_cnt != 3'd0) ? SCK_HIGH :
                                                 (last_flag ? CS_HOLD : IDLE);
            CS_HOLD:  if (div_done) state_next = CS_GAP;
            CS_GAP:   if (div_done) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Datapath: shift register samples CIPO on each rising SCK, bit 7 feeds COPI.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            shreg     <= '0;
            div_cnt   <= '0;
            rx_byte   <= '0;
            bit_cnt   <= '0;
            last_flag <= 1'b0;
            sck       <= 1'b0;
            copi      <= 1'b0;
            cs        <= 1'b1;
            strobe    <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (state_next != state) div_cnt <= DIV_LOAD;
            else if (!div_done)      div_cnt <= div_cnt - 8'd1;
            case (state)
                IDLE: if (accept) begin
                    shreg     <= host.transmit_byte_i;
                    last_flag <= host.last_i;
                    cs        <= 1'b0;
                    copi      <= host.transmit_byte_i[7];
                end
                SETUP: if (div_done) begin
                    sck   <= 1'b1;
                    shreg <= {shreg[6:0], spi_cipo_i};
                end
                SCK_HIGH: if (div_done) begin
                    sck     <= 1'b0;
                    bit_cnt <= bit_cnt + 3'd1;
                    // after the 8th fall COPI keeps the final data bit
                    if (bit_cnt != 3'd7) copi <= shreg[7];
                end
                SCK_LOW: if (div_done) begin
                    if (bit_cnt != 3'd0) begin
                        sck   <= 1'b1;
                        shreg <= {shreg[6:0], spi_cipo_i};
                    end else begin
                        rx_byte <= shreg;
                        strobe  <= 1'b1;
                    end
                end
                CS_HOLD: if (div_done) cs <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        host.busy_o           = (state != IDLE);
        host.receive_strobe_o = strobe;
        host.receive_byte_o   = rx_byte;
        spi_sck_o             = sck;
        spi_copi_o            = copi;
        spi_cs_o              = cs;
    end
endmodule

// File: tb/tb_spi_initiator.sv
// Directed bench: loopback and a behavioural mode-0 target on a D=4 instance,
// loopback on a D=2 instance; timings checked in cycles from the accept cycle.
module tb_spi_initiator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_initiator_if h4();
    spi_initiator_if h2();
    logic sck4, copi4, cs4, cipo4, miso;
    logic sck2, copi2, cs2;
    logic loop4 = 1'b1;

    assign cipo4 = loop4 ? copi4 : miso;

    spi_initiator #(.CLK_DIV(4)) dut4 (.clk(clk), .reset_n_i(rst_n), .host(h4.slave),
        .spi_sck_o(sck4), .spi_copi_o(copi4), .spi_cs_o(cs4), .spi_cipo_i(cipo4));
    spi_initiator #(.CLK_DIV(2)) dut2 (.clk(clk), .reset_n_i(rst_n), .host(h2.slave),
        .spi_sck_o(sck2), .spi_copi_o(copi2), .spi_cs_o(cs2), .spi_cipo_i(copi2));

    int nvec = 0, nerr = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitors, sampled on the falling clk edge
    int         s4_q[$], s2_q[$];
    logic [7:0] r4_q[$], r2_q[$];
    int   cs_rise4 = -1, cs_rise_cnt4 = 0, busy_fall4 = -1, rise4 = 0;
    logic pcs4 = 1'b1, pbusy4 = 1'b0;
    always @(negedge clk) begin
        if (h4.receive_strobe_o) begin s4_q.push_back(cyc); r4_q.push_back(h4.receive_byte_o); end
        if (h2.receive_strobe_o) begin s2_q.push_back(cyc); r2_q.push_back(h2.receive_byte_o); end
        if (cs4 && !pcs4) begin cs_rise4 = cyc; cs_rise_cnt4++; end
        if (!h4.busy_o && pbusy4) busy_fall4 = cyc;
        pcs4   = cs4;
        pbusy4 = h4.busy_o;
    end
    always @(posedge sck4) rise4++;

    // behavioural mode-0 target: samples on SCK rise, shifts on SCK fall
    logic [7:0] t_tx = 8'h00, t_sh = 8'h00, t_rx = 8'h00;
    logic [7:0] tgt_q[$];
    int   t_bit = 0;
    logic t_psck = 1'b0, t_pcs = 1'b1;
    assign miso = t_sh[7];
    always @(sck4 or cs4) begin
        if (t_pcs && !cs4) begin
            t_bit = 0; t_sh = t_tx;
        end else if (!t_psck && sck4) begin
            t_rx = {t_rx[6:0], copi4};
            t_bit++;
            if (t_bit == 8) begin tgt_q.push_back(t_rx); t_bit = 0; end
        end else if (t_psck && !sck4) begin
            if (t_bit == 0) t_sh = t_tx;
            else            t_sh = {t_sh[6:0], 1'b0};
        end
        t_psck = sck4;
        t_pcs  = cs4;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start4(input logic [7:0] tx, input logic last, output int a);
        @(negedge clk);
        h4.start_i = 1'b1; h4.transmit_byte_i = tx; h4.last_i = last; a = cyc;
        @(negedge clk);
        h4.start_i = 1'b0; h4.transmit_byte_i = 8'h00; h4.last_i = 1'b0;
    endtask

    task automatic start2(input logic [7:0] tx, input logic last, output int a);
        @(negedge clk);
        h2.start_i = 1'b1; h2.transmit_byte_i = tx; h2.last_i = last; a = cyc;
        @(negedge clk);
        h2.start_i = 1'b0; h2.transmit_byte_i = 8'h00; h2.last_i = 1'b0;
    endtask

    task automatic wait_idle4();
        int n = 0;
        do begin @(negedge clk); n++; end while (h4.busy_o && n < 300);
        chk("idle4_timeout", h4.busy_o, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle2();
        int n = 0;
        do begin @(negedge clk); n++; end while (h2.busy_o && n < 300);
        chk("idle2_timeout", h2.busy_o, 0);
        repeat (3) @(negedge clk);
    endtask

    int a, a2, bs, bt, br, bc, n;

    initial begin
        h4.start_i = 0; h4.transmit_byte_i = 0; h4.last_i = 0;
        h2.start_i = 0; h2.transmit_byte_i = 0; h2.last_i = 0;
        repeat (3) @(negedge clk);
        chk("rst_cs",     cs4, 1);
        chk("rst_sck",    sck4, 0);
        chk("rst_copi",   copi4, 0);
        chk("rst_busy",   h4.busy_o, 0);
        chk("rst_strobe", h4.receive_strobe_o, 0);
        chk("rst_rx",     h4.receive_byte_o, 8'h00);
        chk("rst_cs2",    cs2, 1);
        rst_n = 1'b1;

        // loopback A5, last
        loop4 = 1'b1; bs = s4_q.size(); br = rise4; bc = cs_rise_cnt4;
        start4(8'hA5, 1'b1, a);
        wait_idle4();
        chk("lb_strobes", s4_q.size() - bs, 1);
        if (s4_q.size() > bs) begin
            chk("lb_strobe_cyc", s4_q[bs] - a, 69);
            chk("lb_rx", r4_q[bs], 8'hA5);
        end
        chk("lb_cs_rise", cs_rise4 - a, 73);
        chk("lb_busy_fall", busy_fall4 - a, 77);
        chk("lb_rises", rise4 - br, 8);
        chk("lb_cs_rise_cnt", cs_rise_cnt4 - bc, 1);

        // behavioural target: target sends 3C, initiator sends C3
        loop4 = 1'b0; t_tx = 8'h3C; bs = s4_q.size(); bt = tgt_q.size();
        start4(8'hC3, 1'b1, a);
        wait_idle4();
        chk("tgt_strobes", s4_q.size() - bs, 1);
        if (s4_q.size() > bs) chk("tgt_init_rx", r4_q[bs], 8'h3C);
        chk("tgt_rx_cnt", tgt_q.size() - bt, 1);
        if (tgt_q.size() > bt) chk("tgt_rx", tgt_q[bt], 8'hC3);

        // two bytes, second start issued in the first strobe cycle
        bs = s4_q.size(); bt = tgt_q.size(); bc = cs_rise_cnt4;
        start4(8'h12, 1'b0, a);
        n = 0;
        do begin @(negedge clk); n++; end while (!h4.receive_strobe_o && n < 200);
        chk("b2b_first_strobe", h4.receive_strobe_o, 1);
        chk("b2b_busy_in_strobe", h4.busy_o, 0);
        chk("b2b_cs_low", cs4, 0);
        h4.start_i = 1'b1; h4.transmit_byte_i = 8'h34; h4.last_i = 1'b1; a2 = cyc;
        @(negedge clk);
        h4.start_i = 1'b0; h4.transmit_byte_i = 8'h00; h4.last_i = 1'b0;
        chk("b2b_accepted", h4.busy_o, 1);
        wait_idle4();
        chk("b2b_strobes", s4_q.size() - bs, 2);
        if (s4_q.size() > bs + 1) begin
            chk("b2b_first_cyc", s4_q[bs] - a, 69);
            chk("b2b_gap", s4_q[bs+1] - s4_q[bs], 69);
            chk("b2b_cs_rise", cs_rise4 - s4_q[bs+1], 4);
        end
        chk("b2b_cs_rise_cnt", cs_rise_cnt4 - bc, 1);
        chk("b2b_tgt_cnt", tgt_q.size() - bt, 2);
        if (tgt_q.size() > bt + 1) begin
            chk("b2b_tgt0", tgt_q[bt], 8'h12);
            chk("b2b_tgt1", tgt_q[bt+1], 8'h34);
        end

        // start held high while busy, TX changes mid-transfer
        loop4 = 1'b1; bs = s4_q.size(); br = rise4;
        @(negedge clk);
        h4.start_i = 1'b1; h4.transmit_byte_i = 8'h96; h4.last_i = 1'b1;
        repeat (10) @(negedge clk);
        h4.transmit_byte_i = 8'hFF;
        repeat (20) @(negedge clk);
        h4.start_i = 1'b0; h4.transmit_byte_i = 8'h00; h4.last_i = 1'b0;
        wait_idle4();
        chk("hold_strobes", s4_q.size() - bs, 1);
        if (s4_q.size() > bs) chk("hold_rx", r4_q[bs], 8'h96);
        chk("hold_rises", rise4 - br, 8);

        // asynchronous reset after the 3rd rising edge
        bs = s4_q.size(); br = rise4;
        start4(8'h3C, 1'b1, a);
        n = 0;
        while (rise4 - br < 3 && n < 200) begin @(negedge clk); n++; end
        chk("mid_reached_3rd_rise", rise4 - br, 3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_cs", cs4, 1);
        chk("mid_sck", sck4, 0);
        chk("mid_busy", h4.busy_o, 0);
        repeat (5) @(negedge clk);
        chk("mid_no_strobe", s4_q.size() - bs, 0);
        rst_n = 1'b1;
        bs = s4_q.size();
        start4(8'h5A, 1'b1, a);
        wait_idle4();
        chk("post_rst_strobes", s4_q.size() - bs, 1);
        if (s4_q.size() > bs) chk("post_rst_rx", r4_q[bs], 8'h5A);

        // D=2 loopback of 00 and FF
        bs = s2_q.size();
        start2(8'h00, 1'b1, a);
        wait_idle2();
        start2(8'hFF, 1'b1, a2);
        wait_idle2();
        chk("d2_strobes", s2_q.size() - bs, 2);
        if (s2_q.size() > bs + 1) begin
            chk("d2_cyc0", s2_q[bs] - a, 35);
            chk("d2_rx0", r2_q[bs], 8'h00);
            chk("d2_cyc1", s2_q[bs+1] - a2, 35);
            chk("d2_rx1", r2_q[bs+1], 8'hFF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
